// File: rtl/fifo_line_serializer_if.sv
// Link bundle between the cache writeback FIFO read port, the serializer and the memory bus.
// master is the serializer side; slave is the FIFO/bus environment side.
interface fifo_line_serializer_if #(
   parameter int CACHE_STR_WIDTH = 64,
   parameter int BUS_WIDTH       = 16
);
   logic                       fifo_empty;
   logic [CACHE_STR_WIDTH-1:0] fifo_dout;
   logic                       fifo_read;
   logic [BUS_WIDTH-1:0]       bus_data;
   logic                       bus_valid;
   logic                       bus_last;
   logic                       bus_ready;

   modport master (
      input  fifo_empty, fifo_dout, bus_ready,
      output fifo_read, bus_data, bus_valid, bus_last
   );

   modport slave (
      output fifo_empty, fifo_dout, bus_ready,
      input  fifo_read, bus_data, bus_valid, bus_last
   );
endinterface

// File: rtl/fifo_line_serializer.sv
// Pops one cache string from the writeback FIFO and streams it LSB-first onto the
// memory bus as BEATS narrow beats under valid/ready. Lives in the FIFO read clock domain.
module fifo_line_serializer #(
   parameter int CACHE_STR_WIDTH = 64,
   parameter int BUS_WIDTH       = 16,
   parameter int BEATS           = CACHE_STR_WIDTH / BUS_WIDTH,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 not_reset,
   fifo_line_serializer_if.master lnk,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] lines_sent
);
   localparam int              BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     next_state_s;
   logic [CACHE_STR_WIDTH-1:0] shift_r;
   logic [BCW-1:0]             beat_cnt_r;
   logic [BCW-1:0]             beat_cnt_inc_s;
   logic                       fifo_read_r;
   logic                       bus_valid_r;
   logic                       bus_last_r;
   logic                       busy_r;
   logic [CNT_WIDTH-1:0]       lines_sent_r;
   logic                       beat_done_s;
   logic                       last_done_s;

   // Handshake decode and next-state selection
   always_comb begin
      beat_done_s    = 1'b0;
      last_done_s    = 1'b0;
      beat_cnt_inc_s = beat_cnt_r + BCW'(1);
      next_state_s   = state_r;
      if (state_r == SEND) begin
         beat_done_s = lnk.bus_ready;
         last_done_s = lnk.bus_ready && (beat_cnt_r == LAST_BEAT);
      end else begin
         beat_done_s = 1'b0;
         last_done_s = 1'b0;
      end
      case (state_r)
         IDLE: begin
            if (!lnk.fifo_empty) begin
               next_state_s = REQ;
            end else begin
               next_state_s = IDLE;
            end
         end
         REQ:  next_state_s = WAIT;
         WAIT: next_state_s = SEND;
         SEND: begin
            if (last_done_s) begin
               next_state_s = lnk.fifo_empty ? IDLE : REQ;
            end else begin
               next_state_s = SEND;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs; outputs are decoded from next_state so they align with the state
   always_ff @(posedge clk or negedge not_reset) begin
      if (!not_reset) begin
         state_r      <= IDLE;
         shift_r      <= '0;
         beat_cnt_r   <= '0;
         fifo_read_r  <= 1'b0;
         bus_valid_r  <= 1'b0;
         bus_last_r   <= 1'b0;
         busy_r       <= 1'b0;
         lines_sent_r <= '0;
      end else begin
         state_r     <= next_state_s;
         fifo_read_r <= (next_state_s == REQ);
         bus_valid_r <= (next_state_s == SEND);
         busy_r      <= (next_state_s != IDLE);
         if (state_r == WAIT) begin
            shift_r    <= lnk.fifo_dout;
            beat_cnt_r <= '0;
            bus_last_r <= 1'b0;
         end else if (beat_done_s) begin
            shift_r    <= shift_r >> BUS_WIDTH;
            beat_cnt_r <= beat_cnt_inc_s;
            bus_last_r <= (beat_cnt_inc_s == LAST_BEAT) && !last_done_s;
         end else begin
            shift_r    <= shift_r;
            beat_cnt_r <= beat_cnt_r;
            bus_last_r <= bus_last_r;
         end
         if (last_done_s) begin
            lines_sent_r <= lines_sent_r + CNT_WIDTH'(1);
         end else begin
            lines_sent_r <= lines_sent_r;
         end
      end
   end

   assign lnk.fifo_read = fifo_read_r;
   assign lnk.bus_valid = bus_valid_r;
   assign lnk.bus_last  = bus_last_r;
   assign lnk.bus_data  = shift_r[BUS_WIDTH-1:0];
   assign busy          = busy_r;
   assign lines_sent    = lines_sent_r;
endmodule

// File: tb/tb_fifo_line_serializer.sv
// Bench for fifo_line_serializer: a transaction-level model predicts every output each
// cycle, and directed tests pin literal beat values, latencies and the counter wrap.
module tb_fifo_line_serializer;
   localparam int CW    = 64;
   localparam int BW    = 16;
   localparam int BEATS = CW / BW;

   logic clk = 1'b0;
   logic not_reset = 1'b0;
   logic busy, busy2;
   logic [15:0] lines_sent;
   logic [1:0]  lines_sent2;

   fifo_line_serializer_if #(.CACHE_STR_WIDTH(CW), .BUS_WIDTH(BW)) ifc ();
   fifo_line_serializer_if #(.CACHE_STR_WIDTH(CW), .BUS_WIDTH(BW)) ifc2 ();

   fifo_line_serializer #(.CACHE_STR_WIDTH(CW), .BUS_WIDTH(BW), .CNT_WIDTH(16)) dut (
      .clk(clk), .not_reset(not_reset), .lnk(ifc.master), .busy(busy), .lines_sent(lines_sent));
   fifo_line_serializer #(.CACHE_STR_WIDTH(CW), .BUS_WIDTH(BW), .CNT_WIDTH(2)) dut_wrap (
      .clk(clk), .not_reset(not_reset), .lnk(ifc2.master), .busy(busy2), .lines_sent(lines_sent2));

   always #5 clk = ~clk;

   // FIFO: written by the stimulus, popped by the DUT
   logic [CW-1:0] mem [0:63];
   int push_cnt = 0;
   int pop_cnt  = 0;
   assign ifc.fifo_empty  = (push_cnt == pop_cnt);
   assign ifc2.fifo_empty = ifc.fifo_empty;
   assign ifc2.fifo_dout  = ifc.fifo_dout;
   assign ifc2.bus_ready  = ifc.bus_ready;

   always @(posedge clk) begin
      if (ifc.fifo_read && pop_cnt < push_cnt) begin
         ifc.fifo_dout <= mem[pop_cnt];
         pop_cnt       <= pop_cnt + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: lead = cycles of read/latency before beats, beat = index in string
   logic        m_busy = 1'b0;
   int          m_lead = 0;
   int          m_beat = 0;
   int          m_lines = 0;
   int          m_pop = 0;
   logic [CW-1:0] m_word = '0;

   always @(posedge clk or negedge not_reset) begin
      if (!not_reset) begin
         m_busy <= 1'b0; m_lead <= 0; m_beat <= 0; m_lines <= 0; m_word <= '0;
      end else if (!m_busy) begin
         if (!ifc.fifo_empty) begin m_busy <= 1'b1; m_lead <= 2; end
      end else if (m_lead == 2) begin
         m_lead <= 1; m_word <= mem[m_pop]; m_pop <= m_pop + 1;
      end else if (m_lead == 1) begin
         m_lead <= 0; m_beat <= 0;
      end else if (ifc.bus_ready) begin
         if (m_beat == BEATS - 1) begin
            m_lines <= m_lines + 1;
            m_beat  <= 0;
            if (!ifc.fifo_empty) m_lead <= 2;
            else m_busy <= 1'b0;
         end else begin
            m_beat <= m_beat + 1;
         end
      end
   end

   // Handshake and read-pulse log for the literal checks
   int cyc = 0;
   int hs_n = 0;
   int rd_n = 0;
   logic [15:0] hs_data [0:255];
   logic        hs_last [0:255];
   int          hs_cyc  [0:255];
   int          rd_cyc  [0:255];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (not_reset && ifc.bus_valid && ifc.bus_ready) begin
         hs_data[hs_n] <= ifc.bus_data;
         hs_last[hs_n] <= ifc.bus_last;
         hs_cyc[hs_n]  <= cyc;
         hs_n          <= hs_n + 1;
      end
      if (not_reset && ifc.fifo_read) begin
         rd_cyc[rd_n] <= cyc;
         rd_n         <= rd_n + 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic          e_valid;
      logic [CW-1:0] sh;
      e_valid = m_busy && (m_lead == 0);
      sh      = m_word >> (BW * m_beat);
      chk("busy", busy, m_busy);
      chk("fifo_read", ifc.fifo_read, m_busy && (m_lead == 2));
      chk("bus_valid", ifc.bus_valid, e_valid);
      chk("bus_last", ifc.bus_last, e_valid && (m_beat == BEATS - 1));
      if (e_valid) chk("bus_data", ifc.bus_data, sh[BW-1:0]);
      if (!not_reset) chk("bus_data_rst", ifc.bus_data, 16'h0000);
      chk("lines_sent", lines_sent, m_lines[15:0]);
      chk("lines_sent_w2", lines_sent2, m_lines[1:0]);
      chk("wrap_valid", ifc2.bus_valid, ifc.bus_valid);
      chk("wrap_read", ifc2.fifo_read, ifc.fifo_read);
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [CW-1:0] w);
      mem[push_cnt] = w;
      push_cnt = push_cnt + 1;
   endtask

   task automatic wait_hs(input int target);
      int k = 0;
      while (hs_n < target && k < 200) begin cycles(1); k++; end
      chk("wait_hs_timeout", 64'(hs_n >= target), 64'd1);
   endtask

   task automatic wait_idle();
      int k = 0;
      cycles(3);
      while ((busy || !ifc.fifo_empty) && k < 500) begin cycles(1); k++; end
      chk("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   initial begin
      int hb, rb;
      logic [15:0] w_beats [0:3];
      w_beats[0] = 16'hCDEF; w_beats[1] = 16'h89AB; w_beats[2] = 16'h4567; w_beats[3] = 16'h0123;
      ifc.bus_ready = 1'b1;
      cycles(3);
      not_reset = 1'b1;
      cycles(1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_lines", lines_sent, 16'd0);

      // 1: single string, ready held high
      hb = hs_n; rb = rd_n;
      push(64'h0123_4567_89AB_CDEF);
      wait_idle();
      chk("t1_hs_count", hs_n - hb, 4);
      chk("t1_rd_pulses", rd_n - rb, 1);
      for (int i = 0; i < 4; i++) begin
         chk("t1_beat", hs_data[hb + i], w_beats[i]);
         chk("t1_last", hs_last[hb + i], (i == 3) ? 1'b1 : 1'b0);
      end
      chk("t1_consecutive", hs_cyc[hb + 3] - hs_cyc[hb], 3);
      chk("t1_lines", lines_sent, 16'd1);

      // 2: backpressure on beat 2
      hb = hs_n;
      push(64'h0123_4567_89AB_CDEF);
      wait_hs(hb + 1);
      ifc.bus_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall_data", ifc.bus_data, 16'h89AB);
         chk("t2_stall_valid", ifc.bus_valid, 1'b1);
         cycles(1);
      end
      ifc.bus_ready = 1'b1;
      wait_idle();
      chk("t2_hs_count", hs_n - hb, 4);
      for (int i = 0; i < 4; i++) chk("t2_beat", hs_data[hb + i], w_beats[i]);
      chk("t2_lines", lines_sent, 16'd2);

      // 3: back-to-back strings
      hb = hs_n; rb = rd_n;
      push(64'h0123_4567_89AB_CDEF);
      push(64'hFEDC_BA98_7654_3210);
      wait_idle();
      chk("t3_hs_count", hs_n - hb, 8);
      chk("t3_beat4", hs_data[hb + 4], 16'h3210);
      chk("t3_beat7", hs_data[hb + 7], 16'hFEDC);
      chk("t3_last7", hs_last[hb + 7], 1'b1);
      chk("t3_gap", hs_cyc[hb + 4] - hs_cyc[hb + 3], 3);
      chk("t3_second_read", rd_cyc[rb + 1] - hs_cyc[hb + 3], 1);
      chk("t3_lines", lines_sent, 16'd4);

      // 4: empty FIFO for 50 cycles
      hb = hs_n; rb = rd_n;
      cycles(50);
      chk("t4_rd_pulses", rd_n - rb, 0);
      chk("t4_hs", hs_n - hb, 0);
      chk("t4_busy", busy, 1'b0);

      // 5: reset during beat 3
      hb = hs_n;
      push(64'h1111_2222_3333_4444);
      wait_hs(hb + 2);
      chk("t5_on_beat3", ifc.bus_data, 16'h2222);
      not_reset = 1'b0;
      #1;
      chk("t5_rst_valid", ifc.bus_valid, 1'b0);
      chk("t5_rst_last", ifc.bus_last, 1'b0);
      chk("t5_rst_read", ifc.fifo_read, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_data", ifc.bus_data, 16'h0000);
      chk("t5_rst_lines", lines_sent, 16'd0);
      cycles(2);
      not_reset = 1'b1;
      cycles(20);
      chk("t5_no_beats", hs_n - hb, 2);
      chk("t5_lines", lines_sent, 16'd0);

      // 6: five strings wrap the 2-bit counter to 1
      for (int i = 0; i < 5; i++) push(64'hA5A5_0000_0000_0000 + 64'(i));
      wait_idle();
      chk("t6_wrap", lines_sent2, 2'd1);
      chk("t6_lines16", lines_sent, 16'd5);

      cycles(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
